fft_bfp_align: RTL

- Output stage placed directly downstream of the last pipeline radix-4 unit.
- Receives per-sample block-floating-point data: mantissa pair plus signed exponent.
- Buffers one full FFT block in a ping-pong memory and finds the block's maximum exponent.
- Replays the block with every mantissa right-shifted to that common exponent, so downstream logic sees one exponent per block.

---
 rtl/fft_bfp_align.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/fft_bfp_align.sv
// Block-floating-point output aligner: buffers one FFT block per ping-pong bank,
// tracks the block's maximum exponent, then replays every mantissa shifted to it.
module fft_bfp_align #(
    parameter int MAN_W   = 16,
    parameter int EXP_W   = 6,
    parameter int MAX_LDN = 11
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             block_sync_i,
    input  logic             data_val_i,
    input  logic [MAN_W-1:0] data_real_i,
    input  logic [MAN_W-1:0] data_imag_i,
    input  logic [EXP_W-1:0] data_exp_i,
    input  logic [3:0]       ldn_rg_i,
    output logic             block_sync_o,
    output logic             data_val_o,
    output logic [MAN_W-1:0] data_real_o,
    output logic [MAN_W-1:0] data_imag_o,
    output logic [EXP_W-1:0] data_exp_o,
    output logic             busy_o,
    output logic             sync_err_o,
    output logic             ovf_o
);

    localparam int WORD_W = 2*MAN_W + EXP_W;
    localparam int DEPTH  = 2**(MAX_LDN+1);
    localparam logic [MAX_LDN-1:0]   IDX_ONE = MAX_LDN'(1);
    localparam logic signed [EXP_W:0] SH_MAX = (EXP_W+1)'(MAN_W-1);

    typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

    // Block length is carried as an N-1 mask so "last index" is a plain compare.
    function automatic logic [MAX_LDN-1:0] len_mask(input logic [3:0] ldn);
        logic [3:0]         l;
        logic [MAX_LDN-1:0] m;
        l = ldn;
        if (l < 4'd2) l = 4'd2;
        else if (l > 4'(MAX_LDN)) l = 4'(MAX_LDN);
        for (int i = 0; i < MAX_LDN; i++) m[i] = (i < int'(l));
        return m;
    endfunction

    function automatic logic [MAN_W-1:0] align(input logic [MAN_W-1:0] man,
                                               input logic [EXP_W-1:0] blk,
                                               input logic [EXP_W-1:0] ex);
        logic signed [EXP_W:0] s;
        logic signed [MAN_W-1:0] m;
        s = $signed({blk[EXP_W-1], blk}) - $signed({ex[EXP_W-1], ex});
        if (s < 0) s = '0;
        else if (s > SH_MAX) s = SH_MAX;
        m = $signed(man);
        return m >>> s;
    endfunction

    // Write side state
    logic               wr_active_q, wr_active_d;
    logic [MAX_LDN-1:0] wr_idx_q, wr_idx_d;
    logic [MAX_LDN-1:0] wr_nm1_q, wr_nm1_d;
    logic [EXP_W-1:0]   max_exp_q, max_exp_d;
    logic               wr_bank_q, wr_bank_d;

    // Read engine state
    rd_state_t          rd_state_q, rd_state_d;
    logic [MAX_LDN-1:0] rd_cnt_q, rd_cnt_d;
    logic [MAX_LDN-1:0] rd_nm1_q, rd_nm1_d;
    logic               rd_bank_q, rd_bank_d;
    logic [EXP_W-1:0]   rd_exp_q, rd_exp_d;

    // Read pipeline: address register, RAM data, aligned output
    logic               p1_val_q, p1_val_d;
    logic               p1_sync_q, p1_sync_d;
    logic [MAX_LDN:0]   p1_addr_q, p1_addr_d;
    logic [EXP_W-1:0]   p1_exp_q, p1_exp_d;
    logic               p2_val_q, p2_val_d;
    logic               p2_sync_q, p2_sync_d;
    logic [EXP_W-1:0]   p2_exp_q, p2_exp_d;
    logic [WORD_W-1:0]  rd_word_q;

    logic               val_o_q, val_o_d;
    logic               sync_o_q, sync_o_d;
    logic [MAN_W-1:0]   real_o_q, real_o_d;
    logic [MAN_W-1:0]   imag_o_q, imag_o_d;
    logic [EXP_W-1:0]   exp_o_q, exp_o_d;
    logic               sync_err_q, sync_err_d;
    logic               ovf_q, ovf_d;

    logic [WORD_W-1:0]  mem_q [DEPTH];

    logic               accept, last, rd_done, rd_free, start;
    logic [MAX_LDN-1:0] idx_eff, nm1_eff;
    logic [EXP_W-1:0]   max_new;
    logic [MAX_LDN:0]   wr_addr;
    logic [WORD_W-1:0]  wr_word;

    always_comb begin
        accept  = data_val_i && (block_sync_i || wr_active_q);
        idx_eff = block_sync_i ? '0 : wr_idx_q;
        nm1_eff = block_sync_i ? len_mask(ldn_rg_i) : wr_nm1_q;
        if (block_sync_i || ($signed(data_exp_i) > $signed(max_exp_q)))
            max_new = data_exp_i;
        else
            max_new = max_exp_q;
        last    = accept && (idx_eff == nm1_eff);
        rd_done = (rd_state_q == RD_READ) && (rd_cnt_q == rd_nm1_q);
        rd_free = (rd_state_q == RD_IDLE) || rd_done;
        start   = last && rd_free;
        wr_addr = {wr_bank_q, idx_eff};
        wr_word = {data_real_i, data_imag_i, data_exp_i};
    end

    always_comb begin
        wr_active_d = wr_active_q;
        wr_idx_d    = wr_idx_q;
        wr_nm1_d    = wr_nm1_q;
        max_exp_d   = max_exp_q;
        wr_bank_d   = wr_bank_q;
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_nm1_d    = rd_nm1_q;
        rd_bank_d   = rd_bank_q;
        rd_exp_d    = rd_exp_q;

        if (accept) begin
            wr_active_d = !last;
            wr_idx_d    = idx_eff + IDX_ONE;
            wr_nm1_d    = nm1_eff;
            max_exp_d   = max_new;
        end

        if (rd_state_q == RD_READ) begin
            rd_cnt_d = rd_cnt_q + IDX_ONE;
            if (rd_done) rd_state_d = RD_IDLE;
        end

        // A completed block that cannot be handed over is dropped; its bank is reused.
        if (start) begin
            rd_state_d = RD_READ;
            rd_cnt_d   = '0;
            rd_nm1_d   = nm1_eff;
            rd_bank_d  = wr_bank_q;
            rd_exp_d   = max_new;
            wr_bank_d  = !wr_bank_q;
        end

        sync_err_d = data_val_i && block_sync_i && wr_active_q;
        ovf_d      = ovf_q || (last && !rd_free);

        p1_val_d  = (rd_state_q == RD_READ);
        p1_sync_d = (rd_state_q == RD_READ) && (rd_cnt_q == '0);
        p1_addr_d = {rd_bank_q, rd_cnt_q};
        p1_exp_d  = rd_exp_q;
        p2_val_d  = p1_val_q;
        p2_sync_d = p1_sync_q;
        p2_exp_d  = p1_exp_q;

        val_o_d  = p2_val_q;
        sync_o_d = p2_sync_q;
        real_o_d = real_o_q;
        imag_o_d = imag_o_q;
        exp_o_d  = exp_o_q;
        if (p2_val_q) begin
            real_o_d = align(rd_word_q[WORD_W-1 -: MAN_W], p2_exp_q, rd_word_q[EXP_W-1:0]);
            imag_o_d = align(rd_word_q[EXP_W +: MAN_W], p2_exp_q, rd_word_q[EXP_W-1:0]);
            exp_o_d  = p2_exp_q;
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            wr_active_q <= 1'b0;
            wr_idx_q    <= '0;
            wr_nm1_q    <= '0;
            max_exp_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_state_q  <= RD_IDLE;
            rd_cnt_q    <= '0;
            rd_nm1_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_exp_q    <= '0;
            p1_val_q    <= 1'b0;
            p1_sync_q   <= 1'b0;
            p1_addr_q   <= '0;
            p1_exp_q    <= '0;
            p2_val_q    <= 1'b0;
            p2_sync_q   <= 1'b0;
            p2_exp_q    <= '0;
            val_o_q     <= 1'b0;
            sync_o_q    <= 1'b0;
            real_o_q    <= '0;
            imag_o_q    <= '0;
            exp_o_q     <= '0;
            sync_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wr_active_q <= wr_active_d;
            wr_idx_q    <= wr_idx_d;
            wr_nm1_q    <= wr_nm1_d;
            max_exp_q   <= max_exp_d;
            wr_bank_q   <= wr_bank_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_nm1_q    <= rd_nm1_d;
            rd_bank_q   <= rd_bank_d;
            rd_exp_q    <= rd_exp_d;
            p1_val_q    <= p1_val_d;
            p1_sync_q   <= p1_sync_d;
            p1_addr_q   <= p1_addr_d;
            p1_exp_q    <= p1_exp_d;
            p2_val_q    <= p2_val_d;
            p2_sync_q   <= p2_sync_d;
            p2_exp_q    <= p2_exp_d;
            val_o_q     <= val_o_d;
            sync_o_q    <= sync_o_d;
            real_o_q    <= real_o_d;
            imag_o_q    <= imag_o_d;
            exp_o_q     <= exp_o_d;
            sync_err_q  <= sync_err_d;
            ovf_q       <= ovf_d;
        end
    end

    // Ping-pong storage; the read address carries its bank so a swap never disturbs it.
    always_ff @(posedge clk_sys) begin
        if (accept) mem_q[wr_addr] <= wr_word;
        rd_word_q <= mem_q[p1_addr_q];
    end

    assign block_sync_o = sync_o_q;
    assign data_val_o   = val_o_q;
    assign data_real_o  = real_o_q;
    assign data_imag_o  = imag_o_q;
    assign data_exp_o   = exp_o_q;
    assign busy_o       = (rd_state_q == RD_READ);
    assign sync_err_o   = sync_err_q;
    assign ovf_o        = ovf_q;

endmodule
